// File: rtl/rate_sched_if.sv
// Config handshake, run control and tick outputs of the rate scheduler.
// The master side drives configuration and control; the slave side is the scheduler.
interface rate_sched_if #(
  parameter int N  = 26,
  parameter int CW = 16
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [N-1:0]  cfg_div;
  logic [CW-1:0] cfg_count;
  logic          start;
  logic          pause;
  logic          stop;
  logic          tick;
  logic          out;
  logic          busy;
  logic          done;
  logic [CW-1:0] remaining;

  modport master (
    output cfg_valid, cfg_div, cfg_count, start, pause, stop,
    input  cfg_ready, tick, out, busy, done, remaining
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_count, start, pause, stop,
    output cfg_ready, tick, out, busy, done, remaining
  );
endinterface

// File: rtl/rate_sched.sv
// Programmable clock-enable scheduler: 1-cycle tick every (div+1) clocks plus a toggled square,
// continuous or for a programmed number of ticks. Every output is registered.
module rate_sched #(
  parameter int N           = 26,
  parameter int DIV_DEFAULT = 25000000,
  parameter int CW          = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rate_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  div_q;
  logic [N-1:0]  cnt_q;
  logic [CW-1:0] cnt_reg_q;
  logic [CW-1:0] rem_q;
  logic          tick_q;
  logic          out_q;
  logic          busy_q;
  logic          done_q;
  logic          ready_q;

  logic          cfg_fire_d;
  logic          terminal_d;
  logic [CW-1:0] run_count_d;

  assign cfg_fire_d  = bus.cfg_valid && ready_q;
  assign terminal_d  = (cnt_q == div_q);
  // A config accepted in the same cycle as start governs that run.
  assign run_count_d = cfg_fire_d ? bus.cfg_count : cnt_reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= N'(DIV_DEFAULT);
      cnt_q     <= '0;
      cnt_reg_q <= '0;
      rem_q     <= '0;
      tick_q    <= 1'b0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          out_q <= 1'b0;
          if (cfg_fire_d) begin
            div_q     <= bus.cfg_div;
            cnt_reg_q <= bus.cfg_count;
          end
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            rem_q   <= run_count_d;
          end
        end
        RUN, PAUSED: begin
          if (bus.stop) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (bus.pause) begin
            state_q <= PAUSED;
          end else begin
            // Resuming from PAUSED also counts this edge, so the delay equals the paused edges.
            state_q <= RUN;
            if (terminal_d) begin
              cnt_q  <= '0;
              tick_q <= 1'b1;
              out_q  <= ~out_q;
              if (rem_q != '0) begin
                rem_q <= rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_q + N'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = ready_q;
  assign bus.tick      = tick_q;
  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_rate_sched.sv
// Directed bench for rate_sched: continuous, counted, same-cycle config, pause/stop and reset.
module tb_rate_sched;

  localparam int N  = 26;
  localparam int CW = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rate_sched_if #(.N(N), .CW(CW)) bus ();

  rate_sched #(.N(N), .DIV_DEFAULT(9), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int div, input int count);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = N'(div);
    bus.cfg_count = CW'(count);
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_div = '0; bus.cfg_count = '0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    #23 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (bus.tick !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle k=%0d got tick=%b busy=%b done=%b out=%b exp all 0",
                 k, bus.tick, bus.busy, bus.done, bus.out);
      end
    end
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", bus.cfg_ready);
    end
    checks++;
    if (bus.remaining !== 16'd0) begin
      errors++; $display("FAIL reset_remaining got %0d exp 0", bus.remaining);
    end
  endtask

  task automatic test_continuous();
    logic exp_tick, exp_out;
    do_cfg(3, 0);
    do_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b0) begin
      errors++; $display("FAIL cont_start got busy=%b ready=%b exp 1 0", bus.busy, bus.cfg_ready);
    end
    for (int k = 1; k <= 80; k++) begin
      step();
      exp_tick = (k % 4 == 0);
      exp_out  = ((k / 4) % 2) == 1;
      checks++;
      if (bus.tick !== exp_tick || bus.out !== exp_out || bus.busy !== 1'b1 ||
          bus.done !== 1'b0 || bus.remaining !== 16'd0) begin
        errors++;
        $display("FAIL cont_run k=%0d got tick=%b out=%b busy=%b done=%b rem=%0d exp tick=%b out=%b busy=1 done=0 rem=0",
                 k, bus.tick, bus.out, bus.busy, bus.done, bus.remaining, exp_tick, exp_out);
      end
    end
    do_stop();
    checks++;
    if (bus.busy !== 1'b0 || bus.tick !== 1'b0 || bus.out !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cont_stop got busy=%b tick=%b out=%b ready=%b exp 0 0 0 1",
               bus.busy, bus.tick, bus.out, bus.cfg_ready);
    end
  endtask

  task automatic test_counted();
    logic exp_tick, exp_done, exp_busy;
    int   exp_rem;
    do_cfg(2, 3);
    do_start();
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) step();
      exp_tick = (k == 3 || k == 6 || k == 9);
      exp_done = (k == 9);
      exp_busy = (k < 9);
      exp_rem  = (k < 9) ? 3 - k / 3 : 0;
      checks++;
      if (bus.tick !== exp_tick || bus.done !== exp_done || bus.busy !== exp_busy ||
          bus.cfg_ready !== ~exp_busy || bus.remaining !== exp_rem[15:0]) begin
        errors++;
        $display("FAIL counted k=%0d got tick=%b done=%b busy=%b ready=%b rem=%0d exp tick=%b done=%b busy=%b rem=%0d",
                 k, bus.tick, bus.done, bus.busy, bus.cfg_ready, bus.remaining,
                 exp_tick, exp_done, exp_busy, exp_rem);
      end
      if (k >= 10) begin
        checks++;
        if (bus.out !== 1'b0) begin
          errors++; $display("FAIL counted_idle_out k=%0d got %b exp 0", k, bus.out);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    logic exp_tick;
    bus.cfg_valid = 1'b1; bus.cfg_div = N'(0); bus.cfg_count = CW'(1); bus.start = 1'b1;
    step();
    bus.cfg_valid = 1'b0; bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.remaining !== 16'd1 || bus.tick !== 1'b0) begin
      errors++; $display("FAIL same_start got busy=%b rem=%0d tick=%b exp 1 1 0",
                         bus.busy, bus.remaining, bus.tick);
    end
    step();
    checks++;
    if (bus.tick !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.remaining !== 16'd0) begin
      errors++; $display("FAIL same_tick got tick=%b done=%b busy=%b rem=%0d exp 1 1 0 0",
                         bus.tick, bus.done, bus.busy, bus.remaining);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.tick !== 1'b0 || bus.done !== 1'b0) begin
        errors++; $display("FAIL same_after k=%0d got tick=%b done=%b exp 0 0", k, bus.tick, bus.done);
      end
    end
    do_cfg(5, 0);
    do_start();
    for (int k = 1; k <= 18; k++) begin
      if (k == 2) begin
        bus.cfg_valid = 1'b1; bus.cfg_div = N'(1); bus.cfg_count = CW'(2);
      end
      if (k == 4) bus.cfg_valid = 1'b0;
      step();
      exp_tick = (k % 6 == 0);
      checks++;
      if (bus.tick !== exp_tick || bus.cfg_ready !== 1'b0 || bus.remaining !== 16'd0) begin
        errors++; $display("FAIL busy_cfg k=%0d got tick=%b ready=%b rem=%0d exp tick=%b ready=0 rem=0",
                           k, bus.tick, bus.cfg_ready, bus.remaining, exp_tick);
      end
    end
    do_stop();
    do_start();
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_tick = (k == 6);
      checks++;
      if (bus.tick !== exp_tick) begin
        errors++; $display("FAIL cfg_ignored k=%0d got tick=%b exp %b", k, bus.tick, exp_tick);
      end
    end
    do_stop();
  endtask

  task automatic test_pause_stop();
    logic exp_tick;
    do_cfg(4, 0);
    do_start();
    for (int k = 1; k <= 14; k++) begin
      bus.pause = (k >= 3 && k <= 7);
      step();
      exp_tick = (k == 10);
      checks++;
      if (bus.tick !== exp_tick || bus.busy !== 1'b1 || bus.out !== (k >= 10)) begin
        errors++; $display("FAIL pause k=%0d got tick=%b busy=%b out=%b exp tick=%b busy=1 out=%b",
                           k, bus.tick, bus.busy, bus.out, exp_tick, (k >= 10));
      end
    end
    bus.pause = 1'b0;
    do_stop();
    checks++;
    if (bus.tick !== 1'b0 || bus.done !== 1'b0 || bus.out !== 1'b0 ||
        bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL stop_terminal got tick=%b done=%b out=%b busy=%b ready=%b exp 0 0 0 0 1",
                         bus.tick, bus.done, bus.out, bus.busy, bus.cfg_ready);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (bus.tick !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL stop_idle k=%0d got tick=%b busy=%b exp 0 0", k, bus.tick, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic exp_tick;
    do_cfg(1, 10);
    do_start();
    repeat (7) step();
    checks++;
    if (bus.remaining !== 16'd7 || bus.out !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset got rem=%0d out=%b busy=%b exp 7 1 1",
                         bus.remaining, bus.out, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.remaining !== 16'd0 || bus.out !== 1'b0 || bus.busy !== 1'b0 ||
        bus.tick !== 1'b0 || bus.done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got rem=%0d out=%b busy=%b tick=%b done=%b ready=%b exp 0 0 0 0 0 1",
                         bus.remaining, bus.out, bus.busy, bus.tick, bus.done, bus.cfg_ready);
    end
    #3 rst_n = 1'b1;
    step();
    do_start();
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_tick = (k == 10);
      checks++;
      if (bus.tick !== exp_tick || bus.remaining !== 16'd0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL default_div k=%0d got tick=%b rem=%0d busy=%b exp tick=%b rem=0 busy=1",
                           k, bus.tick, bus.remaining, bus.busy, exp_tick);
      end
    end
    do_stop();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_continuous();
    test_counted();
    test_same_cycle();
    test_pause_stop();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
